// File: rtl/flag_sequencer.sv
// Frame-synchronous flag index sequencer. It synchronizes and debounces the four flag
// buttons, applies at most one index event per frame tick, and can auto-advance the index.
module flag_sequencer #(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int AUTO_FRAMES     = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_zero,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_load,
    input  logic       auto_en,
    input  logic [6:0] load_value,
    input  logic [6:0] max,
    output logic [6:0] flag_sel,
    output logic       sel_changed,
    output logic       auto_active
);
    localparam int EV_ZERO = 0;
    localparam int EV_NEXT = 1;
    localparam int EV_PREV = 2;
    localparam int EV_LOAD = 3;
    localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_FRAMES);
    localparam logic [9:0] AUTO_LAST = 10'(AUTO_FRAMES - 1);

    logic [4:0]      sync1_q, sync2_q;
    logic [3:0]      deb_q, deb_d;
    logic [3:0][3:0] cnt_q, cnt_d;
    logic [3:0]      pend_q, pend_d;
    logic [9:0]      auto_cnt_q, auto_cnt_d;
    logic [6:0]      sel_q, sel_d;
    logic            changed_q, changed_d;
    logic            manual;

    function automatic logic [6:0] step_next(input logic [6:0] cur, input logic [6:0] top);
        return (cur < top) ? cur + 7'd1 : 7'd0;
    endfunction

    function automatic logic [6:0] step_prev(input logic [6:0] cur, input logic [6:0] top);
        if (cur > top || cur == 7'd0) return top;
        return cur - 7'd1;
    endfunction

    // NOTE: every sequential element uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            auto_cnt_q <= '0;
            sel_q      <= '0;
            changed_q  <= 1'b0;
        end else begin
            sync1_q    <= {auto_en, btn_load, btn_prev, btn_next, btn_zero};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            auto_cnt_q <= auto_cnt_d;
            sel_q      <= sel_d;
            changed_q  <= changed_d;
        end
    end

    // Debounce: presses that flip on this tick become pending for the next tick's commit.
    // NOTE: defaulting every output first keeps this combinational block latch-free.
    always_comb begin
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (frame_tick) begin
            pend_d = '0;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] + 4'd1 == DEB_LIMIT) begin
                    cnt_d[i]  = '0;
                    deb_d[i]  = ~deb_q[i];
                    pend_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Commit: highest-priority earlier pending event wins, otherwise a due auto-next.
    always_comb begin
        sel_d      = sel_q;
        auto_cnt_d = auto_cnt_q;
        changed_d  = 1'b0;
        manual     = |pend_q;
        if (frame_tick) begin
            if (pend_q[EV_ZERO])      sel_d = 7'd0;
            else if (pend_q[EV_NEXT]) sel_d = step_next(sel_q, max);
            else if (pend_q[EV_PREV]) sel_d = step_prev(sel_q, max);
            else if (pend_q[EV_LOAD]) sel_d = (load_value <= max) ? load_value : 7'd0;
            else if (sync2_q[4] && auto_cnt_q == AUTO_LAST) sel_d = step_next(sel_q, max);

            if (!sync2_q[4] || manual || auto_cnt_q == AUTO_LAST) auto_cnt_d = '0;
            else                                                   auto_cnt_d = auto_cnt_q + 10'd1;

            changed_d = (sel_d != sel_q);
        end
    end

    assign flag_sel    = sel_q;
    assign sel_changed = changed_q;
    assign auto_active = sync2_q[4];
endmodule

// File: tb/tb_flag_sequencer.sv
// Directed and randomized bench for flag_sequencer, checked against a per-frame behavioural model.
module tb_flag_sequencer;
    localparam int DEB  = 2;
    localparam int AUTO = 4;
    localparam logic [3:0] ZERO = 4'b0001, NEXT = 4'b0010, PREV = 4'b0100, LOAD = 4'b1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [3:0] btns = '0;
    logic       auto_en = 1'b0;
    logic [6:0] load_value = '0;
    logic [6:0] max = 7'd5;
    logic [6:0] flag_sel;
    logic       sel_changed, auto_active;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    // Model state, kept as whole-frame quantities.
    int m_sel, m_auto, m_load, m_max;
    int m_run[4];
    bit m_deb[4], m_pend[4], m_lvl[4];
    bit m_auto_en, m_chg;

    flag_sequencer #(.DEBOUNCE_FRAMES(DEB), .AUTO_FRAMES(AUTO)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_zero(btns[0]), .btn_next(btns[1]), .btn_prev(btns[2]), .btn_load(btns[3]),
        .auto_en(auto_en), .load_value(load_value), .max(max),
        .flag_sel(flag_sel), .sel_changed(sel_changed), .auto_active(auto_active)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int s, input int top);
        return (s < top) ? s + 1 : 0;
    endfunction

    function automatic int prv(input int s, input int top);
        if (s > top) return top;
        return (s > 0) ? s - 1 : top;
    endfunction

    function automatic void model_reset();
        m_sel = 0; m_auto = 0; m_chg = 0;
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0; m_deb[i] = 0; m_pend[i] = 0;
        end
    endfunction

    function automatic void model_tick();
        int  old;
        bit  manual;
        old    = m_sel;
        manual = m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
        if (m_pend[0])      m_sel = 0;
        else if (m_pend[1]) m_sel = nxt(old, m_max);
        else if (m_pend[2]) m_sel = prv(old, m_max);
        else if (m_pend[3]) m_sel = (m_load <= m_max) ? m_load : 0;
        else if (m_auto_en && m_auto == AUTO - 1) m_sel = nxt(old, m_max);
        m_auto = (!m_auto_en || manual) ? 0 : (m_auto + 1) % AUTO;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            if (m_lvl[i] == m_deb[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i]  = !m_deb[i];
                    m_run[i]  = 0;
                    m_pend[i] = m_deb[i];
                end
            end
        end
        m_chg = (m_sel != old);
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        check("rst.sel", flag_sel, 0);
        check("rst.chg", sel_changed, 0);
        check("rst.auto", auto_active, 0);
    endtask

    // Inputs settle for several clocks, then one frame tick is issued and checked.
    task automatic tick(input string tag);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) m_lvl[i] = btns[i];
        m_auto_en = auto_en;
        m_load    = int'(load_value);
        m_max     = int'(max);
        @(negedge clk) frame_tick = 1'b1;
        @(posedge clk) #1 frame_tick = 1'b0;
        model_tick();
        if (sel_changed === 1'b1) pulses++;
        check({tag, ".sel"}, flag_sel, m_sel);
        check({tag, ".chg"}, sel_changed, m_chg);
        check({tag, ".auto"}, auto_active, m_auto_en);
        @(posedge clk) #1;
        check({tag, ".chg_clr"}, sel_changed, 0);
    endtask

    task automatic press(input logic [3:0] mask, input string tag);
        btns = mask;
        tick(tag); tick(tag);
        btns = '0;
        tick(tag); tick(tag);
    endtask

    initial begin
        int p0;
        model_reset();
        do_reset();

        // Held next: flips on the second tick, commits on the third, no repeat.
        max  = 7'd5;
        btns = NEXT;
        p0   = pulses;
        repeat (4) tick("hold");
        check("hold.sel", flag_sel, 1);
        check("hold.pulses", pulses - p0, 1);
        btns = '0;
        repeat (2) tick("hold_rel");

        // Wrap-around and load range checks.
        load_value = 7'd5; press(LOAD, "ld5");  check("ld5.sel", flag_sel, 5);
        press(NEXT, "wrapn");                   check("wrapn.sel", flag_sel, 0);
        press(PREV, "wrapp");                   check("wrapp.sel", flag_sel, 5);
        load_value = 7'd9; press(LOAD, "ld9");  check("ld9.sel", flag_sel, 0);
        load_value = 7'd3; press(LOAD, "ld3");  check("ld3.sel", flag_sel, 3);

        // Simultaneous zero and next: zero wins, single pulse.
        load_value = 7'd4; press(LOAD, "ld4");  check("ld4.sel", flag_sel, 4);
        p0 = pulses;
        press(ZERO | NEXT, "prio");
        check("prio.sel", flag_sel, 0);
        check("prio.pulses", pulses - p0, 1);

        // One-tick glitch is rejected.
        p0   = pulses;
        btns = NEXT; tick("glitch");
        btns = '0;   repeat (3) tick("glitch");
        check("glitch.sel", flag_sel, 0);
        check("glitch.pulses", pulses - p0, 0);

        // Auto-advance every AUTO ticks; manual prev restarts the period.
        max = 7'd2; auto_en = 1'b1;
        repeat (4) tick("auto"); check("auto.1", flag_sel, 1);
        repeat (4) tick("auto"); check("auto.2", flag_sel, 2);
        repeat (4) tick("auto"); check("auto.0", flag_sel, 0);
        tick("amid");
        btns = PREV; tick("amid"); tick("amid");
        btns = '0;   tick("amid");
        check("amid.prev", flag_sel, 2);
        repeat (3) tick("amid"); check("amid.hold", flag_sel, 2);
        tick("amid");            check("amid.wrap", flag_sel, 0);
        repeat (4) tick("amid"); check("amid.adv", flag_sel, 1);
        auto_en = 1'b0;
        repeat (8) tick("afrz");
        check("afrz.sel", flag_sel, 1);

        // Reset with a pending press discards it.
        max = 7'd5; load_value = 7'd3;
        press(LOAD, "pre");
        check("pre.sel", flag_sel, 3);
        btns = NEXT; tick("pend"); tick("pend");
        btns = '0;
        do_reset();
        repeat (4) tick("post");
        check("post.sel", flag_sel, 0);

        // Randomized frames against the model.
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 2) == 0) btns[i] = ~btns[i];
            if ($urandom_range(0, 9) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 9) == 0) max = 7'($urandom_range(0, 10));
            if ($urandom_range(0, 3) == 0) load_value = 7'($urandom_range(0, 12));
            if ($urandom_range(0, 59) == 0) do_reset();
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
